// File: rtl/spi_mstr_param.sv
// ============================================================================
// spi_mstr_param : parametrised full-duplex SPI master, runtime CPOL/CPHA
// Revision 1.0
// ============================================================================
`default_nettype none

module spi_mstr_param #(
    parameter int DATA_W    = 16,
    parameter int HALF_PER  = 16,
    parameter int SETUP_CYC = 8,
    parameter int NUM_SS    = 1
) (
    input  logic                                             clk,
    input  logic                                             rst_n,
    input  logic                                             wrt,
    input  logic [DATA_W-1:0]                                cmd,
    input  logic [((NUM_SS > 1) ? $clog2(NUM_SS) : 1)-1:0]   ss_sel,
    input  logic                                             cpol,
    input  logic                                             cpha,
    input  logic                                             MISO,
    output logic                                             SCLK,
    output logic                                             MOSI,
    output logic [NUM_SS-1:0]                                SS_n,
    output logic                                             busy,
    output logic                                             done,
    output logic [DATA_W-1:0]                                rd_data
);

    localparam int SS_W    = (NUM_SS > 1) ? $clog2(NUM_SS) : 1;
    localparam int CNT_MAX = (HALF_PER > SETUP_CYC) ? HALF_PER : SETUP_CYC;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);
    localparam int BIT_W   = $clog2(DATA_W);

    localparam logic [CNT_W-1:0] c_HALF_LAST  = CNT_W'(HALF_PER - 1);
    localparam logic [CNT_W-1:0] c_SETUP_LAST = CNT_W'(SETUP_CYC - 1);
    localparam logic [BIT_W-1:0] c_BIT_LAST   = BIT_W'(DATA_W - 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_SETUP = 2'd1,
        S_XFER  = 2'd2,
        S_HOLD  = 2'd3
    } state_t;

    state_t              r_state;
    logic [CNT_W-1:0]    r_cnt;
    logic [BIT_W-1:0]    r_bit;
    logic                r_lead;     // 1 once the leading edge of the current bit has happened
    logic                r_cpha;
    logic                r_sclk;
    logic                r_busy;
    logic                r_done;
    logic [NUM_SS-1:0]   r_ss_n;
    logic [DATA_W-1:0]   r_shift;
    logic [DATA_W-1:0]   r_rx;
    logic [DATA_W-1:0]   r_rd;
    logic [NUM_SS-1:0]   w_ss_dec;

    // An out-of-range index matches no line, so no slave is selected.
    always_comb begin
        w_ss_dec = '1;
        for (int i = 0; i < NUM_SS; i++) begin
            if (ss_sel == SS_W'(i)) begin
                w_ss_dec[i] = 1'b0;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
            r_cnt   <= '0;
            r_bit   <= '0;
            r_lead  <= 1'b0;
            r_cpha  <= 1'b0;
            r_sclk  <= 1'b0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
            r_ss_n  <= '1;
            r_shift <= '0;
            r_rx    <= '0;
            r_rd    <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (wrt) begin
                        r_shift <= cmd;
                        r_ss_n  <= w_ss_dec;
                        r_sclk  <= cpol;
                        r_cpha  <= cpha;
                        r_busy  <= 1'b1;
                        r_done  <= 1'b0;
                        r_cnt   <= '0;
                        r_bit   <= '0;
                        r_lead  <= 1'b0;
                        r_state <= S_SETUP;
                    end
                end
                S_SETUP: begin
                    if (r_cnt == c_SETUP_LAST) begin
                        r_cnt   <= '0;
                        r_state <= S_XFER;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                S_XFER: begin
                    if (r_cnt == c_HALF_LAST) begin
                        r_cnt  <= '0;
                        r_sclk <= ~r_sclk;
                        if (!r_lead) begin
                            r_lead <= 1'b1;
                            if (!r_cpha) begin
                                r_rx <= {r_rx[DATA_W-2:0], MISO};
                            end else if (r_bit != '0) begin
                                r_shift <= {r_shift[DATA_W-2:0], 1'b0};
                            end
                        end else begin
                            r_lead <= 1'b0;
                            if (r_cpha) begin
                                r_rx <= {r_rx[DATA_W-2:0], MISO};
                            end else if (r_bit != c_BIT_LAST) begin
                                r_shift <= {r_shift[DATA_W-2:0], 1'b0};
                            end
                            if (r_bit == c_BIT_LAST) begin
                                r_state <= S_HOLD;
                            end else begin
                                r_bit <= r_bit + 1'b1;
                            end
                        end
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                S_HOLD: begin
                    if (r_cnt == c_SETUP_LAST) begin
                        r_ss_n  <= '1;
                        r_rd    <= r_rx;
                        r_done  <= 1'b1;
                        r_busy  <= 1'b0;
                        r_cnt   <= '0;
                        r_state <= S_IDLE;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign SCLK    = r_sclk;
    assign MOSI    = r_shift[DATA_W-1];
    assign SS_n    = r_ss_n;
    assign busy    = r_busy;
    assign done    = r_done;
    assign rd_data = r_rd;

endmodule

`default_nettype wire

// File: tb/tb_spi_mstr_param.sv
// ============================================================================
// tb_spi_mstr_param : scoreboard bench for spi_mstr_param (16-bit and 8-bit builds)
// Revision 1.0
// ============================================================================
`default_nettype none
`timescale 1ns/1ps

module tb_spi_mstr_param;

    typedef struct {
        logic [15:0] rd;
        int          lat;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic        wrt = 1'b0, cpol = 1'b0, cpha = 1'b0;
    logic [15:0] cmd = '0;
    logic [0:0]  ss_sel = '0;
    logic        MISO, SCLK, MOSI, busy, done;
    logic [1:0]  SS_n;
    logic [15:0] rd_data;

    logic        s_wrt = 1'b0, s_cpol = 1'b0, s_cpha = 1'b0;
    logic [7:0]  s_cmd = '0;
    logic [0:0]  s_ss_sel = '0;
    logic        s_SCLK, s_MOSI, s_busy, s_done;
    logic [0:0]  s_SS_n;
    logic [7:0]  s_rd;

    logic        loopback = 1'b1;
    logic [15:0] slave_pat = '0;
    logic [15:0] slave_tx = '0;
    logic        sclk_d = 1'b0;
    logic [15:0] mosi_cap = '0;
    int          cyc = 0;
    int          errors = 0;
    int          checks = 0;
    exp_t        q_m[$];
    exp_t        q_s[$];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    spi_mstr_param #(.DATA_W(16), .HALF_PER(16), .SETUP_CYC(8), .NUM_SS(2)) dut (
        .clk(clk), .rst_n(rst_n), .wrt(wrt), .cmd(cmd), .ss_sel(ss_sel),
        .cpol(cpol), .cpha(cpha), .MISO(MISO), .SCLK(SCLK), .MOSI(MOSI),
        .SS_n(SS_n), .busy(busy), .done(done), .rd_data(rd_data)
    );

    spi_mstr_param #(.DATA_W(8), .HALF_PER(2), .SETUP_CYC(1), .NUM_SS(1)) dut_s (
        .clk(clk), .rst_n(rst_n), .wrt(s_wrt), .cmd(s_cmd), .ss_sel(s_ss_sel),
        .cpol(s_cpol), .cpha(s_cpha), .MISO(s_MOSI), .SCLK(s_SCLK), .MOSI(s_MOSI),
        .SS_n(s_SS_n), .busy(s_busy), .done(s_done), .rd_data(s_rd)
    );

    // Mode-0 slave: presents its MSB at select, advances after each falling SCLK.
    assign MISO = loopback ? MOSI : slave_tx[15];
    always @(posedge clk) begin
        sclk_d <= SCLK;
        if (!busy)
            slave_tx <= slave_pat;
        else if (sclk_d && !SCLK)
            slave_tx <= {slave_tx[14:0], 1'b0};
    end

    always @(posedge SCLK) mosi_cap <= {mosi_cap[14:0], MOSI};

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    initial begin : mon_main
        int   acc;
        logic bq, dq;
        exp_t e;
        acc = 0; bq = 1'b0; dq = 1'b0;
        forever begin
            @(negedge clk);
            if (busy && !bq) acc = cyc;
            if (done && !dq) begin
                if (q_m.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL main_unexpected_done: rd_data %0h with nothing expected", rd_data);
                end else begin
                    e = q_m.pop_front();
                    chk("main_rd_data", rd_data, e.rd);
                    chk("main_done_latency", cyc - acc, e.lat);
                end
            end
            bq = busy; dq = done;
        end
    end

    initial begin : mon_small
        int   acc;
        logic bq, dq;
        exp_t e;
        acc = 0; bq = 1'b0; dq = 1'b0;
        forever begin
            @(negedge clk);
            if (s_busy && !bq) acc = cyc;
            if (s_done && !dq) begin
                if (q_s.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL small_unexpected_done: rd_data %0h with nothing expected", s_rd);
                end else begin
                    e = q_s.pop_front();
                    chk("small_rd_data", {24'd0, s_rd}, e.rd);
                    chk("small_done_latency", s_done ? cyc - acc : 0, e.lat);
                end
            end
            bq = s_busy; dq = s_done;
        end
    end

    task automatic start_m(input logic [15:0] c, input logic s, input logic pol, input logic pha,
                           input logic push, input logic [15:0] exp_rd);
        @(negedge clk);
        cmd = c; ss_sel = s; cpol = pol; cpha = pha; wrt = 1'b1;
        if (push) q_m.push_back('{exp_rd, 528});
        @(negedge clk);
        wrt = 1'b0;
        chk("main_busy_after_accept", busy, 1);
    endtask

    task automatic wait_m(input int budget);
        int n = 0;
        while (busy && n < budget) begin
            @(negedge clk);
            n++;
        end
        chk("main_busy_timeout", busy, 0);
    endtask

    task automatic run_s(input logic [7:0] c, input logic pol, input logic pha);
        @(negedge clk);
        s_cmd = c; s_cpol = pol; s_cpha = pha; s_wrt = 1'b1;
        q_s.push_back('{{8'd0, c}, 34});
        @(negedge clk);
        s_wrt = 1'b0;
        for (int n = 0; n < 100 && s_busy; n++) @(negedge clk);
        chk("small_busy_timeout", s_busy, 0);
        chk("small_idle_sclk", s_SCLK, pol);
    endtask

    initial begin : wdog
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin : stim
        #1 rst_n = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_sclk", SCLK, 0);
        chk("rst_mosi", MOSI, 0);
        chk("rst_ss_n", SS_n, 2'b11);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_rd_data", rd_data, 0);
        rst_n = 1'b1;
        @(negedge clk);

        // Reduced build: 8 bits, fastest SCLK, single setup cycle.
        run_s(8'h5A, 1'b0, 1'b0);
        run_s(8'h5A, 1'b1, 1'b1);

        // Mode 0 against an independent slave, slave 1 selected.
        loopback = 1'b0;
        slave_pat = 16'h3C5A;
        start_m(16'hA5C3, 1'b1, 1'b0, 1'b0, 1'b1, 16'h3C5A);
        repeat (100) @(negedge clk);
        chk("m0_ss_n_during", SS_n, 2'b01);
        wait_m(700);
        chk("m0_mosi_stream", mosi_cap, 16'hA5C3);
        chk("m0_done_sticky", done, 1);
        chk("m0_ss_n_after", SS_n, 2'b11);
        loopback = 1'b1;

        for (int m = 1; m < 4; m++) begin
            logic [1:0] md;
            md = 2'(m);
            start_m(16'h8001, 1'b0, md[1], md[0], 1'b1, 16'h8001);
            chk("mode_setup_sclk", SCLK, md[1]);
            wait_m(700);
            chk("mode_idle_sclk", SCLK, md[1]);
        end

        // A request during XFER must be ignored entirely.
        start_m(16'h1234, 1'b0, 1'b0, 1'b0, 1'b1, 16'h1234);
        repeat (200) @(negedge clk);
        cmd = 16'hFFFF; cpol = 1'b1; cpha = 1'b1; ss_sel = 1'b1; wrt = 1'b1;
        @(negedge clk);
        wrt = 1'b0;
        chk("midwrt_ss_n", SS_n, 2'b10);
        chk("midwrt_busy", busy, 1);
        wait_m(700);

        // Abort in the middle of bit 7 (E0 + 8 + 7*32 + 16).
        start_m(16'hFFFF, 1'b1, 1'b0, 1'b0, 1'b0, 16'h0000);
        repeat (247) @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("abort_ss_n", SS_n, 2'b11);
        chk("abort_sclk", SCLK, 0);
        chk("abort_busy", busy, 0);
        chk("abort_done", done, 0);
        chk("abort_rd_data", rd_data, 0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        chk("abort_done_after", done, 0);
        chk("abort_rd_after", rd_data, 0);
        start_m(16'h0F0F, 1'b1, 1'b1, 1'b1, 1'b1, 16'h0F0F);
        wait_m(700);

        // Back-to-back with wrt held high.
        @(negedge clk);
        cmd = 16'hC3C3; ss_sel = 1'b1; cpol = 1'b0; cpha = 1'b0; wrt = 1'b1;
        q_m.push_back('{16'hC3C3, 528});
        q_m.push_back('{16'hC3C3, 528});
        @(negedge clk);
        chk("b2b_busy", busy, 1);
        wait_m(700);
        chk("b2b_gap_ss_n", SS_n, 2'b11);
        chk("b2b_gap_done", done, 1);
        @(negedge clk);
        chk("b2b_next_ss_n", SS_n, 2'b01);
        chk("b2b_next_done", done, 0);
        chk("b2b_next_busy", busy, 1);
        wrt = 1'b0;
        wait_m(700);

        repeat (5) @(negedge clk);
        chk("main_queue_empty", q_m.size(), 0);
        chk("small_queue_empty", q_s.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/spi_mstr_param.md
# spi_mstr_param

Parametrised SPI master and the successor to the fixed 16-bit, mode-0 master. It shifts one `DATA_W`-bit word full-duplex per `wrt` request. It supports runtime-selectable SPI mode (CPOL/CPHA), a configurable SCLK rate, configurable SS setup/hold, and up to `NUM_SS` slave selects. It sits between the command/control logic and the off-chip SPI peripherals (inertial sensor, A2D).

## Interface
- `DATA_W`, 16: bits per transaction; must be ≥2.
- `HALF_PER`, 16: clk cycles per SCLK half-period; must be ≥2.
- `SETUP_CYC`, 8: clk cycles between SS_n fall and XFER start; also between XFER end and SS_n rise. Must be ≥1.
- `NUM_SS`, 1: number of slave-select lines; must be ≥1.
- `clk`  in  1  system clock.
- `rst_n`  in  1  reset, asynchronous, active-low.
- `wrt`  in  1  start request; accepted only in IDLE.
- `cmd`  in  DATA_W  word to transmit, MSB first; captured on the accepting edge.
- `ss_sel`  in  max(1,$clog2(NUM_SS))  slave index; captured with `cmd`.
- `cpol`, `cpha`  in  1 each  SPI mode; captured with `cmd`.
- `MISO`  in  1  serial data from slave.
- `SCLK`  out  1  serial clock; reset 0.
- `MOSI`  out  1  serial data, equal to shift-register MSB; reset 0.
- `SS_n`  out  NUM_SS  active-low selects; reset all 1.
- `busy`  out  1  high from the accepting edge until the edge that returns to IDLE; reset 0.
- `done`  out  1  sticky completion flag; reset 0.
- `rd_data`  out  DATA_W  received word; reset 0.

## Operation
States and transitions:
- **IDLE**: on `wrt`, latch `cmd`, `ss_sel`, `cpol`, `cpha`.
  - Same edge: shift register ← `cmd`; `SS_n[ss_sel]` ← 0; `SCLK` ← latched `cpol`; `busy` ← 1; `done` ← 0.
  - Go to SETUP.
- **SETUP**: hold for `SETUP_CYC` cycles with SCLK at `cpol`, then go to XFER.
- **XFER**: run `DATA_W` SCLK periods of `2*HALF_PER` cycles each.
  - A leading edge (SCLK leaves `cpol`) occurs `HALF_PER` cycles into each period.
  - A trailing edge occurs at the period end.
  - After the last trailing edge, go to HOLD.
- **HOLD**: hold for `SETUP_CYC` cycles with SCLK at `cpol` and SS_n still low. Then on one edge:
  - all `SS_n` ← 1;
  - `rd_data` ← receive register;
  - `done` ← 1;
  - `busy` ← 0;
  - go to IDLE.

Mode rules:
- SCLK is a register. "At an edge" means on the clk edge where SCLK toggles; MISO is sampled with its value before that edge.
- cpha=0:
  - MOSI holds `cmd` MSB from SS_n fall.
  - Sample MISO into the receive LSB (shift left) on every leading edge.
  - Shift MOSI left on every trailing edge except the last.
- cpha=1:
  - Shift MOSI left on every leading edge except the first.
  - Sample MISO on every trailing edge.
- Exactly `DATA_W` samples and `DATA_W−1` MOSI shifts occur per transaction.

Boundary conditions:
- `wrt` while busy: ignored. No restart, `done` unchanged, latched fields unchanged.
- `wrt` in IDLE with `done`=1: `done` clears on the accepting edge.
- `ss_sel` ≥ `NUM_SS`: the transfer runs normally with no SS_n asserted.
- `rd_data` changes only on the HOLD→IDLE edge; it holds its value otherwise.
- `rst_n` low at any time: all outputs and state return to reset values immediately; the transfer is aborted, and `done` and `rd_data` are not updated.
- Mode inputs may change while busy without effect.

## Timing
- Accepting edge = E0. SCLK's first toggle occurs at E0 + `SETUP_CYC` + `HALF_PER`.
- Last SCLK trailing edge occurs at E0 + `SETUP_CYC` + `DATA_W*2*HALF_PER`.
- `SS_n` rise, `done` rise and `busy` fall all occur at E0 + `2*SETUP_CYC` + `DATA_W*2*HALF_PER`. With default parameters this is E0 + 528.
- The earliest next accepted `wrt` is the cycle after `busy` falls. SS_n is therefore high for ≥1 cycle between transfers.
- SCLK duty is exactly 50%, frequency is clk/(2*`HALF_PER`), and SCLK has no glitches.

## Test plan
- Mode 0, defaults, `NUM_SS`=2, `cmd`=16'hA5C3, `ss_sel`=1, slave model returns 16'h3C5A:
  - MOSI bit stream reads A5C3 at the leading edges;
  - `rd_data`=16'h3C5A;
  - `SS_n`=2'b01 during the transfer;
  - `done` rises exactly 528 cycles after E0.
- Modes 1, 2 and 3 with `cmd`=16'h8001 and a loopback (MISO=MOSI):
  - `rd_data`=16'h8001 in each mode;
  - idle SCLK equals `cpol`;
  - sampling occurs on the correct edge per mode.
- `wrt` pulsed mid-XFER with a different `cmd`: the transfer completes unchanged, and `done`/`rd_data` reflect the first word only.
- `rst_n` asserted in the middle of the 8th bit:
  - SS_n goes to all 1, SCLK=0, `busy`=0, `done`=0, `rd_data` keeps its reset value 0;
  - a new transfer after release completes correctly.
- Back-to-back: `wrt` held high continuously.
  - `done` clears at each acceptance;
  - SS_n is high for exactly 1 cycle between transfers.
- Param sweep `DATA_W`=8, `HALF_PER`=2, `SETUP_CYC`=1, `cmd`=8'h5A, loopback:
  - `rd_data`=8'h5A;
  - `done` rises at E0 + 34.
